// File: rtl/execute_stage_if.sv
// execute_stage_if
//   Bundles the ID/EX inputs, forwarding controls and EX/MEM outputs of the
//   RV32I execute stage.
//   Modports:
//     master - upstream side (ID/EX register, hazard unit, writeback source).
//              It drives the E-stage fields and observes the branch and M outputs.
//     slave  - the execute stage itself.
//   Signals:
//     RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE : control
//     RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE                           : data
//     ForwardAE, ForwardBE, ResultW                                     : forwarding
//     PCSrcE, PCTargetE                                                 : branch (comb)
//     RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RDM,
//     PCPlus4M                                                          : EX/MEM register
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // ID/EX control
  logic              RegWriteE;
  logic              ALUSrcE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic [2:0]        ALUControlE;
  // ID/EX data
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] ImmExtE;
  logic [DATA_W-1:0] PCE;
  logic [DATA_W-1:0] PCPlus4E;
  logic [ADDR_W-1:0] RDE;
  // forwarding
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;
  // branch resolution
  logic              PCSrcE;
  logic [DATA_W-1:0] PCTargetE;
  // EX/MEM register
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [ADDR_W-1:0] RDM;
  logic [DATA_W-1:0] PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE,
    output ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE,
    input  RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RDM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE,
    input  ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE,
    output RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RDM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage of the 5-stage RV32I pipeline. Selects forwarded operands,
//   runs the ALU, resolves beq (taken flag + target) combinationally and
//   captures results/control into the EX/MEM register every cycle.
//   Ports:
//     clk - clock
//     rst - asynchronous, active-low reset (clears the EX/MEM register only)
//     bus - execute_stage_if.slave: ID/EX inputs, forwarding, branch and M outputs
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  execute_stage_if.slave       bus
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ---------------------------------------------------------------------------
  // Forwarding muxes: index 0 is operand A (RD1), index 1 is operand B (RD2).
  // Code 11 is reserved and falls back to the register-file value.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_val   [2];
  logic [1:0]        fwd_sel  [2];
  logic [DATA_W-1:0] fwd_val  [2];
  logic [DATA_W-1:0] alu_result_reg;

  assign rf_val[0]  = bus.RD1E;
  assign rf_val[1]  = bus.RD2E;
  assign fwd_sel[0] = bus.ForwardAE;
  assign fwd_sel[1] = bus.ForwardBE;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_val[gi] = rf_val[gi];
        case (fwd_sel[gi])
          FWD_RF:  fwd_val[gi] = rf_val[gi];
          FWD_WB:  fwd_val[gi] = bus.ResultW;
          // EX-to-EX bypass uses the value already sitting in EX/MEM
          FWD_MEM: fwd_val[gi] = alu_result_reg;
          default: fwd_val[gi] = rf_val[gi];
        endcase
      end
    end
  endgenerate

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] src_b;

  assign src_a      = fwd_val[0];
  // Store data is always the forwarded RD2, independent of ALUSrcE
  assign write_data = fwd_val[1];
  assign src_b      = bus.ALUSrcE ? bus.ImmExtE : write_data;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_result;
  logic              slt_bit;

  assign slt_bit = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = '0;
    case (bus.ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt_bit};
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch resolution (beq): taken when the subtract result is zero.
  // The target is produced every cycle; fetch only uses it when PCSrcE is high.
  // ---------------------------------------------------------------------------
  logic zero;

  assign zero          = (alu_result == '0);
  assign bus.PCSrcE    = bus.BranchE & zero;
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

  // ---------------------------------------------------------------------------
  // EX/MEM register: loads every cycle, bubbles arrive as zeroed control.
  // ---------------------------------------------------------------------------
  logic              reg_write_reg;
  logic              mem_write_reg;
  logic              result_src_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] pc_plus4_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_reg  <= 1'b0;
      mem_write_reg  <= 1'b0;
      result_src_reg <= 1'b0;
      alu_result_reg <= '0;
      write_data_reg <= '0;
      rd_reg         <= '0;
      pc_plus4_reg   <= '0;
    end else begin
      reg_write_reg  <= bus.RegWriteE;
      mem_write_reg  <= bus.MemWriteE;
      result_src_reg <= bus.ResultSrcE;
      alu_result_reg <= alu_result;
      write_data_reg <= write_data;
      rd_reg         <= bus.RDE;
      pc_plus4_reg   <= bus.PCPlus4E;
    end
  end

  assign bus.RegWriteM  = reg_write_reg;
  assign bus.MemWriteM  = mem_write_reg;
  assign bus.ResultSrcM = result_src_reg;
  assign bus.ALUResultM = alu_result_reg;
  assign bus.WriteDataM = write_data_reg;
  assign bus.RDM        = rd_reg;
  assign bus.PCPlus4M   = pc_plus4_reg;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Directed and randomized checks of execute_stage against a behavioural
//   reference model (operand selection, ALU arithmetic, beq, EX/MEM capture,
//   asynchronous reset).
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  execute_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model of the EX/MEM register contents
  logic [31:0] m_alu;
  logic [31:0] m_wd;
  logic [31:0] m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw, m_rs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return bus.ResultW;
    if (sel == 2'd2) return m_alu;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd1: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0;
    m_rw = 1'b0; m_mw = 1'b0; m_rs = 1'b0;
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".RegWriteM"},  bus.RegWriteM,  m_rw);
    chk({tag, ".MemWriteM"},  bus.MemWriteM,  m_mw);
    chk({tag, ".ResultSrcM"}, bus.ResultSrcM, m_rs);
    chk({tag, ".ALUResultM"}, bus.ALUResultM, m_alu);
    chk({tag, ".WriteDataM"}, bus.WriteDataM, m_wd);
    chk({tag, ".RDM"},        bus.RDM,        32'(m_rd));
    chk({tag, ".PCPlus4M"},   bus.PCPlus4M,   m_pc4);
  endtask

  // Called just after a rising edge with fresh inputs applied: checks the
  // combinational branch outputs, clocks once, then checks the M outputs.
  task automatic cycle(input string tag);
    logic [31:0] a, wd, b, res;
    #1;
    a   = fwd_ref(bus.ForwardAE, bus.RD1E);
    wd  = fwd_ref(bus.ForwardBE, bus.RD2E);
    b   = bus.ALUSrcE ? bus.ImmExtE : wd;
    res = alu_ref(bus.ALUControlE, a, b);
    chk({tag, ".PCSrcE"},    bus.PCSrcE,    (bus.BranchE && res == 32'd0) ? 32'd1 : 32'd0);
    chk({tag, ".PCTargetE"}, bus.PCTargetE, 32'((longint'(bus.PCE) + longint'(bus.ImmExtE)) % 64'h1_0000_0000));
    @(posedge clk);
    #1;
    m_alu = res;
    m_wd  = wd;
    m_pc4 = bus.PCPlus4E;
    m_rd  = bus.RDE;
    m_rw  = bus.RegWriteE;
    m_mw  = bus.MemWriteE;
    m_rs  = bus.ResultSrcE;
    check_m(tag);
    $display("cycle %s op=%0d alu=%h wd=%h", tag, bus.ALUControlE, m_alu, m_wd);
  endtask

  task automatic set_plain(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2);
    bus.RegWriteE = 1'b1; bus.ALUSrcE = 1'b0; bus.MemWriteE = 1'b0; bus.ResultSrcE = 1'b0;
    bus.BranchE = 1'b0; bus.ALUControlE = op; bus.RD1E = rd1; bus.RD2E = rd2;
    bus.ImmExtE = 32'h0; bus.PCE = 32'h40; bus.PCPlus4E = 32'h44; bus.RDE = 5'd3;
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.ResultW = 32'h0;
  endtask

  logic [2:0]  sweep_op  [6];
  logic [31:0] sweep_exp [6];

  initial begin
    sweep_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
    sweep_exp = '{32'h0000_0000, 32'hFFFF_FFE0, 32'h0000_0010, 32'hFFFF_FFF0, 32'h1, 32'h0};
    model_reset();

    // Reset held low with every input nonzero
    bus.RegWriteE = 1'b1; bus.ALUSrcE = 1'b1; bus.MemWriteE = 1'b1; bus.ResultSrcE = 1'b1;
    bus.BranchE = 1'b1; bus.ALUControlE = 3'd3; bus.RD1E = 32'h1234; bus.RD2E = 32'h5678;
    bus.ImmExtE = 32'h9; bus.PCE = 32'h100; bus.PCPlus4E = 32'h104; bus.RDE = 5'd7;
    bus.ForwardAE = 2'b01; bus.ForwardBE = 2'b10; bus.ResultW = 32'hABCD;
    repeat (3) @(posedge clk);
    #1;
    check_m("reset_hold");

    // First capture after release: 5 + 7
    rst = 1'b1;
    set_plain(3'd0, 32'd5, 32'd7);
    cycle("first_add");
    chk("first_add.value", bus.ALUResultM, 32'd12);
    chk("first_add.rw", bus.RegWriteM, 32'd1);

    // ALU sweep, SrcB supplied through the immediate path
    for (int i = 0; i < 6; i++) begin
      set_plain(sweep_op[i], 32'hFFFF_FFF0, 32'h0);
      bus.ALUSrcE = 1'b1;
      bus.ImmExtE = 32'h10;
      cycle($sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d.value", i), bus.ALUResultM, sweep_exp[i]);
    end

    // beq resolved in the same cycle, no clock edge needed
    set_plain(3'd1, 32'h20, 32'h20);
    bus.BranchE = 1'b1; bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
    #1;
    chk("beq_taken.PCSrcE", bus.PCSrcE, 32'd1);
    chk("beq_taken.PCTargetE", bus.PCTargetE, 32'h0000_00F8);
    bus.RD2E = 32'h21;
    #1;
    chk("beq_not_taken.PCSrcE", bus.PCSrcE, 32'd0);
    cycle("beq_not_taken");

    // Forwarding: EX/MEM and writeback sources together
    set_plain(3'd0, 32'h10, 32'h20);
    cycle("fwd_c1");
    chk("fwd_c1.value", bus.ALUResultM, 32'h30);
    set_plain(3'd0, 32'h999, 32'h777);
    bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'h5;
    cycle("fwd_c2");
    chk("fwd_c2.value", bus.ALUResultM, 32'h35);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_m("async_rst");
    @(posedge clk);
    #1;
    check_m("async_rst_hold");
    rst = 1'b1;

    // Reserved select 11 falls back to RD1E; ALUResultM is 0 after reset
    set_plain(3'd0, 32'h100, 32'h1);
    bus.ForwardAE = 2'b11;
    cycle("fwd_rsvd");
    chk("fwd_rsvd.value", bus.ALUResultM, 32'h101);

    // Both operands from EX/MEM
    set_plain(3'd0, 32'h0, 32'h0);
    bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b10;
    cycle("fwd_both");
    chk("fwd_both.value", bus.ALUResultM, 32'h202);

    // Store: address from immediate, data from writeback forward
    set_plain(3'd0, 32'h1000, 32'h4444);
    bus.MemWriteE = 1'b1; bus.RegWriteE = 1'b0; bus.ALUSrcE = 1'b1;
    bus.ImmExtE = 32'h8; bus.ForwardBE = 2'b01; bus.ResultW = 32'hDEAD;
    cycle("store");
    chk("store.addr", bus.ALUResultM, 32'h1008);
    chk("store.data", bus.WriteDataM, 32'hDEAD);
    chk("store.mw", bus.MemWriteM, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      bus.RegWriteE   = 1'($urandom);
      bus.ALUSrcE     = 1'($urandom);
      bus.MemWriteE   = 1'($urandom);
      bus.ResultSrcE  = 1'($urandom);
      bus.BranchE     = 1'($urandom);
      bus.ALUControlE = 3'($urandom);
      bus.RD1E        = $urandom;
      bus.RD2E        = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
      bus.ImmExtE     = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      bus.PCE         = $urandom;
      bus.PCPlus4E    = bus.PCE + 32'd4;
      bus.RDE         = 5'($urandom);
      bus.ForwardAE   = 2'($urandom);
      bus.ForwardBE   = 2'($urandom);
      bus.ResultW     = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
      cycle($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
